// File: rtl/div_datapath.sv
// Datapath for a restoring shift-subtract unsigned divider: the divisor register is
// normalised left, then walked back right while quotient bits are produced.
module div_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             init,
  input  logic             left,
  input  logic             right,
  input  logic             sub,
  output logic             divisor_is_zero,
  output logic             divisor_msb,
  output logic             cnt_is_zero,
  output logic             dvsr_less_than_dvnd,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;

  logic w_dvsr_zero;
  logic w_dvsr_msb;
  logic w_cnt_zero;
  logic w_dvsr_le;
  logic w_qbit;

  // Status is derived purely from registers so the controller sees stable flags.
  assign w_dvsr_zero = (r_dvsr == '0);
  assign w_dvsr_msb  = r_dvsr[WIDTH-1];
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_dvsr_le   = (r_dvsr <= r_rem);
  assign w_qbit      = sub & w_dvsr_le;

  assign divisor_is_zero     = w_dvsr_zero;
  assign divisor_msb         = w_dvsr_msb;
  assign cnt_is_zero         = w_cnt_zero;
  assign dvsr_less_than_dvnd = w_dvsr_le;
  assign quotient            = r_quo;
  assign remainder           = r_rem;

  // Right has priority over left; subtraction runs alongside either shift and is
  // suppressed whenever it would underflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvsr <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
    end else if (init) begin
      r_dvsr <= divisor;
      r_rem  <= dividend;
      r_quo  <= '0;
      r_cnt  <= CW'(1);
    end else begin
      if (right) begin
        if (!w_cnt_zero) begin
          r_dvsr <= r_dvsr >> 1;
          r_cnt  <= r_cnt - CW'(1);
          r_quo  <= {r_quo[WIDTH-2:0], w_qbit};
        end
      end else if (left && !w_dvsr_msb && !w_dvsr_zero) begin
        r_dvsr <= r_dvsr << 1;
        r_cnt  <= r_cnt + CW'(1);
      end
      if (sub && w_dvsr_le) begin
        r_rem <= r_rem - r_dvsr;
      end
    end
  end

endmodule

// File: tb/tb_div_datapath.sv
// Self-checking bench for div_datapath: directed corner cases plus a random sweep
// compared against plain integer division.
module tb_div_datapath;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             init;
  logic             left;
  logic             right;
  logic             sub;
  logic             divisor_is_zero;
  logic             divisor_msb;
  logic             cnt_is_zero;
  logic             dvsr_less_than_dvnd;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  int compared   = 0;
  int mismatched = 0;

  div_datapath #(.WIDTH(WIDTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .dividend            (dividend),
    .divisor             (divisor),
    .init                (init),
    .left                (left),
    .right               (right),
    .sub                 (sub),
    .divisor_is_zero     (divisor_is_zero),
    .divisor_msb         (divisor_msb),
    .cnt_is_zero         (cnt_is_zero),
    .dvsr_less_than_dvnd (dvsr_less_than_dvnd),
    .quotient            (quotient),
    .remainder           (remainder)
  );

  always #5 clk = ~clk;

  // One clock, then sample safely after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: number of leading zeros of a nonzero divisor.
  function automatic int refLz(input int b);
    int n = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if ((b >> i) & 1) break;
      n++;
    end
    return n;
  endfunction

  task automatic clearControls();
    init  = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    sub   = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".quotient"}, quotient, 0);
    checkOutput({tag, ".remainder"}, remainder, 0);
    checkOutput({tag, ".dz"}, divisor_is_zero, 1);
    checkOutput({tag, ".msb"}, divisor_msb, 0);
    checkOutput({tag, ".cntz"}, cnt_is_zero, 1);
    checkOutput({tag, ".le"}, dvsr_less_than_dvnd, 1);
  endtask

  task automatic doInit(input int a, input int b, input logic noise);
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    init     = 1'b1;
    left     = noise;
    right    = noise;
    sub      = noise;
    tick();
    clearControls();
  endtask

  // Full reference control sequence; expectations come from integer arithmetic.
  task automatic applyStimulus(input string tag, input int a, input int b, input logic bothLR,
                               input logic noisyInit);
    int s;
    int lefts;
    int rights;
    s      = refLz(b);
    lefts  = 0;
    rights = 0;
    doInit(a, b, noisyInit);
    checkOutput({tag, ".init_quo"}, quotient, 0);
    checkOutput({tag, ".init_rem"}, remainder, a);
    checkOutput({tag, ".init_msb"}, divisor_msb, (b >> (WIDTH - 1)) & 1);
    while (!divisor_msb && lefts <= WIDTH) begin
      left = 1'b1;
      tick();
      lefts++;
    end
    left = 1'b0;
    checkOutput({tag, ".lefts"}, lefts, s);
    while (!cnt_is_zero && rights <= 2 * WIDTH) begin
      right = 1'b1;
      sub   = 1'b1;
      left  = bothLR;
      tick();
      rights++;
    end
    clearControls();
    checkOutput({tag, ".rights"}, rights, s + 1);
    checkOutput({tag, ".latency"}, 1 + lefts + rights, 1 + s + (s + 1));
    checkOutput({tag, ".quotient"}, quotient, a / b);
    checkOutput({tag, ".remainder"}, remainder, a % b);
    checkOutput({tag, ".cntz"}, cnt_is_zero, 1);
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    dividend = '0;
    divisor  = '0;
    clearControls();
    tick();
    tick();
    checkResetState("reset");
    reset = 1'b0;
    tick();
    checkResetState("idle_after_reset");

    applyStimulus("d100_7", 100, 7, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("hold.quotient", quotient, 14);
    checkOutput("hold.remainder", remainder, 2);
    right = 1'b1;
    sub   = 1'b1;
    tick();
    clearControls();
    checkOutput("right_at_cnt0.quotient", quotient, 14);
    checkOutput("right_at_cnt0.remainder", remainder, 2);

    applyStimulus("d200_200", 200, 200, 1'b0, 1'b0);

    doInit(5, 0, 1'b0);
    checkOutput("zero.dz", divisor_is_zero, 1);
    for (int i = 0; i < 3; i++) begin
      left = 1'b1;
      tick();
    end
    clearControls();
    checkOutput("zero.dz_after_left", divisor_is_zero, 1);
    checkOutput("zero.msb", divisor_msb, 0);
    checkOutput("zero.cntz", cnt_is_zero, 0);
    checkOutput("zero.remainder", remainder, 5);
    checkOutput("zero.quotient", quotient, 0);

    doInit(3, 10, 1'b0);
    checkOutput("small.le", dvsr_less_than_dvnd, 0);
    sub = 1'b1;
    tick();
    clearControls();
    checkOutput("small.sub_ignored_rem", remainder, 3);
    checkOutput("small.sub_ignored_cntz", cnt_is_zero, 0);
    applyStimulus("d3_10", 3, 10, 1'b1, 1'b0);

    // Reset in the middle of the quotient phase.
    doInit(100, 7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      left = 1'b1;
      tick();
    end
    left  = 1'b0;
    right = 1'b1;
    sub   = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clearControls();
    checkResetState("midreset");

    // Restart mid-operation with a noisy init carrying different operands.
    doInit(100, 7, 1'b0);
    left = 1'b1;
    tick();
    tick();
    left = 1'b0;
    applyStimulus("restart_200_13", 200, 13, 1'b0, 1'b1);

    applyStimulus("d255_1", 255, 1, 1'b1, 1'b0);
    applyStimulus("d0_9", 0, 9, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      applyStimulus("rand", a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
